mem_stage_ctrl: RTL

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl_pkg.sv | 22 ++
 rtl/mem_stage_ctrl_reg.sv | 32 +++
 rtl/mem_stage_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM stage controller: FSM state encoding,
// write-back source select codes and the word-alignment helper.
package mem_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Write-back source select codes carried through MEM/WB untouched
  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_PC  = 2'd2;
  localparam logic [1:0] SEL_LT  = 2'd3;

  // Memory is word addressed on the bus; drop the byte offset
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_reg.sv
// Pipeline register with load enable and a bubble override.
// bubble has priority over load_en and forces bubble_val into the register.
module mem_stage_ctrl_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic             bubble,
  input  logic [WIDTH-1:0] bubble_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // Storage: reset clears, bubble injects, load captures, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= '0;
    end else if (bubble) begin
      q_r <= bubble_val;
    end else if (load_en) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: issues one memory request per load/store, stalls the
// front of the pipeline while the access is outstanding, abandons the access
// after TIMEOUT_CYCLES cycles in REQ, and feeds the MEM/WB register.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  // EX/MEM
  input  logic [31:0] next_pc_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] mem_write_data_in,
  input  logic [4:0]  reg_dest_in,
  input  logic        mem_write_en_in,
  input  logic        mem_read_en_in,
  input  logic        reg_write_en_in,
  input  logic [1:0]  reg_data_sel_in,
  input  logic        less_than_in,
  // Memory bus
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  // Pipeline control
  output logic        stall,
  output logic        bus_err,
  // MEM/WB
  output logic [31:0] next_pc_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] read_data_out,
  output logic [4:0]  reg_dest_out,
  output logic        reg_write_en_out,
  output logic [1:0]  reg_data_sel_out,
  output logic        less_than_out
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES);

  state_e         state_r;
  state_e         state_nxt_s;
  logic           mem_op_s;
  logic           stall_s;
  logic           mem_req_s;
  logic           ack_s;
  logic           timeout_s;
  logic           mwb_load_s;
  logic [CW-1:0]  wait_cnt_r;
  logic [CW-1:0]  wait_cnt_inc_s;
  logic [31:0]    mem_addr_r;
  logic [31:0]    mem_wdata_r;
  logic           mem_we_r;
  logic [31:0]    rdata_r;
  logic [31:0]    read_data_s;
  logic           bus_err_r;

  assign mem_op_s       = mem_read_en_in | mem_write_en_in;
  assign wait_cnt_inc_s = wait_cnt_r + CW'(1);

  // Next-state and per-state control decode
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    mem_req_s   = 1'b0;
    ack_s       = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mem_op_s) begin
          stall_s     = 1'b1;
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        stall_s   = 1'b1;
        mem_req_s = 1'b1;
        if (mem_ack) begin
          ack_s       = 1'b1;
          state_nxt_s = ST_DONE;
        end else if (wait_cnt_inc_s == TIMEOUT_LAST) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_DONE: begin
        // EX/MEM still shows the finished instruction; never restart it
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Wait counter: cycles spent in REQ for the current access
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else if (state_r == ST_REQ) begin
      wait_cnt_r <= wait_cnt_inc_s;
    end else begin
      wait_cnt_r <= '0;
    end
  end

  // Request attributes latched on entry to REQ and held until the access ends
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_r  <= 32'h0;
      mem_wdata_r <= 32'h0;
      mem_we_r    <= 1'b0;
    end else if ((state_r == ST_IDLE) && mem_op_s) begin
      mem_addr_r  <= word_align(alu_res_in);
      mem_wdata_r <= mem_write_data_in;
      mem_we_r    <= mem_write_en_in;
    end else begin
      mem_addr_r  <= mem_addr_r;
      mem_wdata_r <= mem_wdata_r;
      mem_we_r    <= mem_we_r;
    end
  end

  // Completion capture: read data on ack (zero for writes), zero and error on timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r   <= 32'h0;
      bus_err_r <= 1'b0;
    end else begin
      bus_err_r <= timeout_s;
      if (ack_s) begin
        rdata_r <= mem_we_r ? 32'h0 : mem_rdata;
      end else if (timeout_s) begin
        rdata_r <= 32'h0;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  // Stall-driven outputs are forced low while reset is asserted
  assign stall     = stall_s & ~rst;
  assign mem_req   = mem_req_s & ~rst;
  assign bus_err   = bus_err_r & ~rst;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_we    = mem_we_r;

  // MEM/WB advances whenever the pipeline is not stalled
  assign mwb_load_s  = ~stall_s;
  assign read_data_s = (state_r == ST_DONE) ? rdata_r : 32'h0;

  mem_stage_ctrl_reg #(.WIDTH(32)) u_next_pc (
    .clk(clk), .rst(rst), .load_en(mwb_load_s), .bubble(1'b0),
    .bubble_val(32'h0), .d(next_pc_in), .q(next_pc_out)
  );

  mem_stage_ctrl_reg #(.WIDTH(32)) u_alu_res (
    .clk(clk), .rst(rst), .load_en(mwb_load_s), .bubble(1'b0),
    .bubble_val(32'h0), .d(alu_res_in), .q(alu_res_out)
  );

  mem_stage_ctrl_reg #(.WIDTH(32)) u_read_data (
    .clk(clk), .rst(rst), .load_en(mwb_load_s), .bubble(1'b0),
    .bubble_val(32'h0), .d(read_data_s), .q(read_data_out)
  );

  mem_stage_ctrl_reg #(.WIDTH(5)) u_reg_dest (
    .clk(clk), .rst(rst), .load_en(mwb_load_s), .bubble(1'b0),
    .bubble_val(5'd0), .d(reg_dest_in), .q(reg_dest_out)
  );

  // Register write enable is the only field cleared while stalled
  mem_stage_ctrl_reg #(.WIDTH(1)) u_reg_write_en (
    .clk(clk), .rst(rst), .load_en(1'b1), .bubble(stall_s),
    .bubble_val(1'b0), .d(reg_write_en_in), .q(reg_write_en_out)
  );

  mem_stage_ctrl_reg #(.WIDTH(2)) u_reg_data_sel (
    .clk(clk), .rst(rst), .load_en(mwb_load_s), .bubble(1'b0),
    .bubble_val(2'd0), .d(reg_data_sel_in), .q(reg_data_sel_out)
  );

  mem_stage_ctrl_reg #(.WIDTH(1)) u_less_than (
    .clk(clk), .rst(rst), .load_en(mwb_load_s), .bubble(1'b0),
    .bubble_val(1'b0), .d(less_than_in), .q(less_than_out)
  );

endmodule
